fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port between NUM_REQ independent producers. It sits in the write clock domain directly in front of the FIFO. It converts per-requester valid/ready handshakes into the FIFO's `wr_en`/`wr_data` and honours the `full` flag. Each grant is held for a bounded burst so that back-to-back producer words stay contiguous in the FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one FIFO word.
- `NUM_REQ`, 4: number of requesters, ≥1.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.

Ports:
- `wr_clk`  in  1  write-domain clock; the block's only clock.
- `wr_rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i's word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `full`  in  1  FIFO full flag, write domain.
- `wr_en`  out  1  FIFO write enable.
- `wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  high while in ARB_BURST.

## Operation
- **States:** ARB_IDLE and ARB_BURST. Registers: `state`, `owner` (index), `rr_ptr` (index), `beat_cnt` (width $clog2(MAX_BURST)+1).
- **ARB_IDLE:**
  - If any `req_valid` bit is set, pick the first set bit searching upward from `rr_ptr` with wrap.
  - On the next edge: `owner` = that index, `beat_cnt` = 0, go to ARB_BURST.
  - No transfer takes place in ARB_IDLE.
- **ARB_BURST:**
  - `grant[owner]` = 1.
  - A beat transfers when `req_valid[owner] && !full`. In that case `wr_en` = 1, `req_ready[owner]` = 1, `wr_data` = the owner's slice, and `beat_cnt` increments.
- **Burst end:** go to ARB_IDLE and set `rr_ptr` = (owner+1) mod NUM_REQ on either of:
  - a transfer with `beat_cnt` == MAX_BURST-1, or
  - `req_valid[owner]` low in ARB_BURST, with no transfer that cycle.
- **Full:** while `full` is high, `wr_en` and `req_ready` are 0. Grant and `beat_cnt` hold. There is no timeout; the burst resumes when `full` drops.
- **Non-owners:** `req_ready` stays 0. The requester must hold its `req_valid` and data stable until accepted.
- **wr_data outside a transfer:** 0 whenever `wr_en` = 0.
- **Invariant:** `wr_en` is never 1 in a cycle where `full` is 1.
- **NUM_REQ = 1:** degenerates to a pass-through with one idle cycle per burst.
- **MAX_BURST = 1:** strict per-word round robin.

## Timing
- **Reset values:** `wr_rst` sampled high at a `wr_clk` edge sets `state` = ARB_IDLE, `owner` = 0, `rr_ptr` = 0, `beat_cnt` = 0. `grant`, `req_ready`, `wr_en`, `wr_data` and `busy` are 0 from that edge on.
- **Reset mid-burst:** the burst is abandoned. No `wr_en` is issued in the cycle after the reset edge.
- **Arbitration latency:** 1 cycle. `req_valid` rising in ARB_IDLE gives `grant` and the first possible `wr_en` on the following cycle.
- **Output paths:** `req_ready`, `wr_en` and `wr_data` are combinational from the registered owner/state plus `req_valid` and `full`. `grant` and `busy` are pure register decodes.
- **Turnaround:** exactly one idle cycle between consecutive bursts.
- **Sustained throughput:** with `full` = 0 and all requesters valid, MAX_BURST words per MAX_BURST+1 cycles.
- **Same-cycle events:** in the cycle of a burst-ending transfer, the word is written and the state moves to ARB_IDLE on the same edge.

## Structure
- **Package `fifo_arb_pkg`:** typedef enum `arb_state_e` {ARB_IDLE, ARB_BURST}.
- **Sub-module `rr_picker`:** combinational rotating-priority encoder with inputs `req` [NUM_REQ] and `ptr`, and outputs `found` and `idx`.
- **Top level:** FSM, counters and the data mux.

## Test plan
- **Single burst:** NUM_REQ=4, MAX_BURST=4, `full`=0. Requester 0 presents 0x11, 0x22, 0x33, then drops valid.
  - Required: `grant`=0001 one cycle after valid, then `wr_en` on 3 consecutive cycles with data 0x11, 0x22, 0x33.
  - Then ARB_IDLE with `rr_ptr`=1.
- **All requesters continuous:** all 4 requesters valid.
  - Required: grants in order 0, 1, 2, 3, 0, each exactly 4 beats, with one idle cycle between bursts.
  - Total: 20 words in 25 cycles.
- **Full mid-burst:** requester 1 owns the grant; `full` rises after its 2nd beat and is held for 5 cycles.
  - Required: `wr_en`=0 and `req_ready`=0 for those 5 cycles, `grant` stays 0010.
  - Beats 3 and 4 follow immediately after `full` falls. `wr_en`∧`full` is never true.
- **Reset mid-burst:** `wr_rst` is pulsed during requester 2's burst.
  - Required: the next cycle shows `grant`=0 and `wr_en`=0.
  - With requesters 0 and 2 then valid, the grant goes to 0 (`rr_ptr` reset).
- **Non-owner holding:** requester 3 is valid with 0xA5 while requester 1 owns a 4-beat burst.
  - Required: `req_ready[3]`=0 throughout that burst.
  - 0xA5 is then written after one idle cycle, ahead of requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// holding each grant for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] pick_idx, owner_next;
  logic             pick_found, owner_vld, xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy       = (state_q == ARB_BURST);
  assign owner_vld  = req_valid[owner_q];
  assign xfer       = busy && owner_vld && !full;
  assign wr_en      = xfer;
  assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Output decode: data is forced to zero outside a transfer.
  always_comb begin
    grant     = '0;
    req_ready = '0;
    wr_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        grant[i]     = busy;
        req_ready[i] = xfer;
        if (xfer) wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      default: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = owner_next;
          end
        end else if (!owner_vld) begin
          // Producer went quiet: release early rather than idle on the grant.
          state_d  = ARB_IDLE;
          rr_ptr_d = owner_next;
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NUM_REQ=4, MAX_BURST=4.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic           wr_clk = 1'b0;
  logic           wr_rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           full;
  logic           wr_en;
  logic [DW-1:0]  wr_data;
  logic [NR-1:0]  grant;
  logic           busy;

  int n_vec = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] v);
    req_data[idx*DW +: DW] = v;
  endtask

  task automatic do_reset();
    wr_rst    = 1'b1;
    req_valid = '0;
    full      = 1'b0;
    tick();
    wr_rst    = 1'b0;
  endtask

  task automatic test_reset();
    wr_rst    = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    full      = 1'b0;
    tick();
    #1;
    n_vec++;
    if ({grant, req_ready, wr_en, wr_data, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs grant=%b ready=%b wr_en=%b data=%h busy=%b expected all 0",
               grant, req_ready, wr_en, wr_data, busy);
    end
    wr_rst    = 1'b0;
    req_valid = '0;
    tick();
    #1;
    n_vec++;
    if ({grant, wr_en, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_idle grant=%b wr_en=%b busy=%b expected 0", grant, wr_en, busy);
    end
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    set_data(0, 8'h11);
    req_valid = 4'b0001;
    #1;
    n_vec++;
    if (wr_en !== 1'b0 || grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_idle wr_en=%b grant=%b expected 0/0000", wr_en, grant);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      set_data(0, exp_d[b]);
      #1;
      n_vec++;
      if (grant !== 4'b0001 || wr_en !== 1'b1 || wr_data !== exp_d[b] || req_ready !== 4'b0001) begin
        n_bad++;
        $display("FAIL single_beat%0d grant=%b wr_en=%b data=%h ready=%b expected 0001/1/%h/0001",
                 b, grant, wr_en, wr_data, req_ready, exp_d[b]);
      end
    end
    tick();
    req_valid = 4'b0000;
    #1;
    n_vec++;
    if (wr_en !== 1'b0 || wr_data !== 8'h00 || grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_drop wr_en=%b data=%h grant=%b expected 0/00/0001", wr_en, wr_data, grant);
    end
    tick();
    req_valid = 4'b0011;
    #1;
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle_after grant=%b busy=%b expected 0000/0", grant, busy);
    end
    // rr_ptr must now be 1, so requester 1 wins over requester 0
    tick();
    #1;
    n_vec++;
    if (grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_rrptr grant=%b expected 0010", grant);
    end
  endtask

  task automatic test_all_continuous();
    logic [NR-1:0] eg;
    logic [DW-1:0] ed;
    logic          ew;
    int            words;
    do_reset();
    for (int i = 0; i < NR; i++) set_data(i, 8'(8'hA0 + i));
    req_valid = 4'hF;
    words = 0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) tick();
      #1;
      if (c % 5 == 0) begin
        eg = '0;
        ew = 1'b0;
        ed = '0;
      end else begin
        eg = 4'(1 << ((c / 5) % 4));
        ew = 1'b1;
        ed = 8'(8'hA0 + (c / 5) % 4);
      end
      if (wr_en) words++;
      n_vec++;
      if (grant !== eg || wr_en !== ew || wr_data !== ed || req_ready !== (ew ? eg : 4'b0)) begin
        n_bad++;
        $display("FAIL all_cycle%0d grant=%b wr_en=%b data=%h ready=%b expected %b/%b/%h",
                 c, grant, wr_en, wr_data, req_ready, eg, ew, ed);
      end
    end
    n_vec++;
    if (words !== 20) begin
      n_bad++;
      $display("FAIL all_words got=%0d expected 20", words);
    end
    req_valid = '0;
  endtask

  task automatic test_full_mid_burst();
    do_reset();
    set_data(1, 8'h40);
    req_valid = 4'b0010;
    #1;
    n_vec++;
    if (wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL full_idle wr_en=%b expected 0", wr_en);
    end
    tick();
    #1;
    n_vec++;
    if (wr_en !== 1'b1 || wr_data !== 8'h40 || grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL full_beat1 wr_en=%b data=%h grant=%b expected 1/40/0010", wr_en, wr_data, grant);
    end
    tick();
    set_data(1, 8'h41);
    #1;
    n_vec++;
    if (wr_en !== 1'b1 || wr_data !== 8'h41) begin
      n_bad++;
      $display("FAIL full_beat2 wr_en=%b data=%h expected 1/41", wr_en, wr_data);
    end
    tick();
    set_data(1, 8'h42);
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      n_vec++;
      if (wr_en !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0010 || wr_data !== 8'h00) begin
        n_bad++;
        $display("FAIL full_hold%0d wr_en=%b ready=%b grant=%b data=%h expected 0/0000/0010/00",
                 k, wr_en, req_ready, grant, wr_data);
      end
    end
    tick();
    full = 1'b0;
    #1;
    n_vec++;
    if (wr_en !== 1'b1 || wr_data !== 8'h42 || grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL full_beat3 wr_en=%b data=%h grant=%b expected 1/42/0010", wr_en, wr_data, grant);
    end
    tick();
    set_data(1, 8'h43);
    #1;
    n_vec++;
    if (wr_en !== 1'b1 || wr_data !== 8'h43) begin
      n_bad++;
      $display("FAIL full_beat4 wr_en=%b data=%h expected 1/43", wr_en, wr_data);
    end
    tick();
    req_valid = '0;
    #1;
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0 || wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL full_end grant=%b busy=%b wr_en=%b expected 0000/0/0", grant, busy, wr_en);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_data(0, 8'h0C);
    set_data(2, 8'h77);
    req_valid = 4'b0100;
    tick();
    #1;
    n_vec++;
    if (grant !== 4'b0100 || wr_en !== 1'b1 || wr_data !== 8'h77) begin
      n_bad++;
      $display("FAIL rstmid_beat1 grant=%b wr_en=%b data=%h expected 0100/1/77", grant, wr_en, wr_data);
    end
    tick();
    wr_rst = 1'b1;
    tick();
    #1;
    n_vec++;
    if (grant !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_after grant=%b wr_en=%b busy=%b expected 0000/0/0", grant, wr_en, busy);
    end
    wr_rst    = 1'b0;
    req_valid = 4'b0101;
    tick();
    #1;
    n_vec++;
    if (grant !== 4'b0001 || wr_en !== 1'b1 || wr_data !== 8'h0C) begin
      n_bad++;
      $display("FAIL rstmid_regrant grant=%b wr_en=%b data=%h expected 0001/1/0c", grant, wr_en, wr_data);
    end
    req_valid = '0;
  endtask

  task automatic test_non_owner();
    do_reset();
    set_data(0, 8'h0F);
    set_data(1, 8'h50);
    set_data(3, 8'hA5);
    req_valid = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      tick();
      set_data(1, 8'(8'h50 + b));
      req_valid = 4'b1011;
      #1;
      n_vec++;
      if (req_ready !== 4'b0010 || grant !== 4'b0010 || wr_data !== 8'(8'h50 + b)) begin
        n_bad++;
        $display("FAIL nonown_beat%0d ready=%b grant=%b data=%h expected 0010/0010/%h",
                 b, req_ready, grant, wr_data, 8'(8'h50 + b));
      end
    end
    tick();
    req_valid = 4'b1001;
    #1;
    n_vec++;
    if (grant !== 4'b0000 || wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL nonown_idle grant=%b wr_en=%b ready=%b expected 0000/0/0000", grant, wr_en, req_ready);
    end
    tick();
    #1;
    n_vec++;
    if (grant !== 4'b1000 || wr_en !== 1'b1 || wr_data !== 8'hA5 || req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL nonown_a5 grant=%b wr_en=%b data=%h ready=%b expected 1000/1/a5/1000",
               grant, wr_en, wr_data, req_ready);
    end
    tick();
    req_valid = 4'b0001;
    #1;
    n_vec++;
    if (wr_en !== 1'b0 || grant !== 4'b1000) begin
      n_bad++;
      $display("FAIL nonown_release wr_en=%b grant=%b expected 0/1000", wr_en, grant);
    end
    tick();
    tick();
    #1;
    n_vec++;
    if (grant !== 4'b0001 || wr_data !== 8'h0F) begin
      n_bad++;
      $display("FAIL nonown_next grant=%b data=%h expected 0001/0f", grant, wr_data);
    end
    req_valid = '0;
  endtask

  always @(negedge wr_clk) begin
    if (wr_en && full) begin
      n_vec++;
      n_bad++;
      $display("FAIL wr_en_while_full wr_en=%b full=%b expected never both 1", wr_en, full);
    end
  end

  initial begin
    wr_rst    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    test_reset();
    test_single_burst();
    test_all_continuous();
    test_full_mid_burst();
    test_reset_mid_burst();
    test_non_owner();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached expected bench completion");
    $fatal(1);
  end

endmodule
